// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: MDOp encodings, latency
// defaults, FSM state encoding and the ALU opcode constants of the core.
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // MDOp encodings; any value not listed here is a NOP.
  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MFHI  = 4'd4;
  localparam logic [3:0] MD_MFLO  = 4'd5;
  localparam logic [3:0] MD_MTHI  = 4'd6;
  localparam logic [3:0] MD_MTLO  = 4'd7;
  localparam logic [3:0] MD_NOP   = 4'd15;

  // ALU opcodes of the surrounding core.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide on the latched op and operands. Produces the
// {HI,LO} result and a divide-by-zero flag; the top decides whether to commit.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [63:0]       result,
  output logic              div_zero
);

  logic [63:0]       a_sx;
  logic [63:0]       b_sx;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] b_safe;
  logic [DATA_W-1:0] uq;
  logic [DATA_W-1:0] ur;
  logic [DATA_W-1:0] sq;
  logic [DATA_W-1:0] sr;

  // Signed division goes through magnitudes so that 0x80000000 / -1 wraps
  // to 0x80000000 instead of relying on simulator overflow behaviour.
  always_comb begin
    a_sx     = {{32{a[31]}}, a};
    b_sx     = {{32{b[31]}}, b};
    a_mag    = a[31] ? (~a + 32'd1) : a;
    b_mag    = b[31] ? (~b + 32'd1) : b;
    div_zero = is_div_op(op) && (b == '0);
    // Divider never sees zero, keeping the datapath free of X.
    b_safe   = (b == '0) ? 32'd1 : b;
    uq       = a / b_safe;
    ur       = a % b_safe;
    sq       = a_mag / ((b_mag == '0) ? 32'd1 : b_mag);
    sr       = a_mag % ((b_mag == '0) ? 32'd1 : b_mag);
    if (a[31] ^ b[31]) sq = ~sq + 32'd1;
    if (a[31])         sr = ~sr + 32'd1;
    result = '0;
    case (op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV:   result = {sr, sq};
      MD_DIVU:  result = {ur, uq};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
//
// Handshake: Start is a one-cycle request qualified by MDOp 0-3 and is only
// accepted in IDLE. Busy is the registered "in flight" indication; the hazard
// unit stalls on Start|Busy. Start seen while Busy is high is dropped, and
// the result commits on the same edge that lowers Busy.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] RData1,
  input  logic [DATA_W-1:0] RData2,
  input  logic [3:0]        MDOp,
  input  logic              Start,
  output logic              Busy,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [DATA_W-1:0] Out,
  output state_e            dbg_state
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [63:0]       calc_result;
  logic              calc_div_zero;

  mdu_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  // FSM: launch in IDLE, count down in RUN, commit HI/LO when count hits 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start && is_launch_op(MDOp)) begin
            op_q  <= MDOp;
            a_q   <= RData1;
            b_q   <= RData2;
            cnt   <= is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state <= ST_RUN;
          end else if (MDOp == MD_MTHI) begin
            hi_q <= RData1;
          end else if (MDOp == MD_MTLO) begin
            lo_q <= RData1;
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            if (!calc_div_zero) begin
              hi_q <= calc_result[63:32];
              lo_q <= calc_result[31:0];
            end
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = (state == ST_RUN);
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state;

  // Read port: old HI/LO are returned even while an op is in flight.
  always_comb begin
    Out = '0;
    if (MDOp == MD_MFHI)      Out = hi_q;
    else if (MDOp == MD_MFLO) Out = lo_q;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: MDU

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 RData1  input  32  operand A: dividend or multiplicand; MTHI/MTLO source.
REQ-006 RData2  input  32  operand B: divisor or multiplier.
REQ-007 MDOp  input  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO, other NOP.
REQ-008 Start  input  1  one-cycle pulse launching MDOp 0-3.
REQ-009 Busy  output  1  registered; high while an operation is in flight.
REQ-010 HI  output  32  HI register.
REQ-011 LO  output  32  LO register.
REQ-012 Out  output  32  combinational read: HI when MDOp=4, LO when MDOp=5, else 0.

Function
REQ-013 States: IDLE, RUN; Busy SHALL equal (state==RUN).
REQ-014 IDLE with Start=1 and MDOp in 0-3: latch operands and op, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
REQ-015 Start with MDOp outside 0-3: ignored, no state change.
REQ-016 RUN: counter decrements each edge; on the edge where counter equals 1, HI/LO take the result, Busy falls, state returns to IDLE.
REQ-017 Latency: Start sampled at edge t0; Busy high for exactly L cycles; new HI/LO visible after edge t0+L, together with Busy=0.
REQ-018 Start during RUN: ignored; in-flight operation unaffected.
REQ-019 Operand changes during RUN: no effect; operands latched at t0.
REQ-020 MULT: {HI,LO} = signed 32x32 -> 64-bit product; MULTU: unsigned product.
REQ-021 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no error flag.
REQ-023 Divisor zero (DIV or DIVU): full latency still taken, HI and LO unchanged.
REQ-024 MTHI/MTLO in IDLE: HI or LO <= RData1 at the edge, independent of Start; during RUN ignored.
REQ-025 MFHI/MFLO during RUN: Out returns current (old) HI/LO; stalling is the hazard unit's job, using Start|Busy.
REQ-026 MDU raises no overflow indication.

Reset
REQ-027 reset_n low asynchronously forces state IDLE, Busy=0, counter=0, HI=0, LO=0, latched operands=0.
REQ-028 Reset asserted mid-RUN aborts the operation; HI/LO read 0, not the partial result.
REQ-029 First Start accepted on the first rising edge after reset_n deasserts.

Structure
REQ-030 Shared package holds the MDOp encodings, MULT_CYCLES/DIV_CYCLES defaults, and the IDLE/RUN state encoding; the ALU opcode constants sit in the same package.
REQ-031 Result datapath SHALL be a behavioural combinational multiply/divide on latched operands, with registered commit; no iterative divider is required.
REQ-032 One sub-module is natural: MDU_Calc, combinational, latched op and operands -> 64-bit {HI,LO} result plus a divide-by-zero flag.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003, Start one cycle -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV -7 / 2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 with HI=0x11, LO=0x22 preloaded -> HI/LO unchanged after 10 cycles.
REQ-036 MULT 2x3 in flight, second Start DIV 9/3 at cycle 2, MTLO 0x55 at cycle 3 -> both ignored; final HI=0, LO=6 at cycle 5.
REQ-037 DIV launched, reset_n pulsed low at cycle 4 -> Busy=0 and HI=LO=0 immediately; new MULT 4x4 after release gives LO=0x10.
REQ-038 MTHI 0xDEADBEEF, then MDOp=4 -> Out=0xDEADBEEF same cycle; MDOp=5 -> Out=LO; MDOp=9 -> Out=0.
